// File: rtl/vector_pkg.sv
// Shared definitions for the vector collect/subtract datapath: index width helper and index type.
package vector_pkg;

    // Index width for an N-element vector; idx runs 0..N-1.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_N = 3;

    typedef logic [idx_w(DEFAULT_N)-1:0] vec_idx_t;

endpackage

// File: rtl/vector_pair_collect_ctrl.sv
// Element index counter with completion, flush and framing decode for vector_pair_collect.
// Framing check is present only when VECTOR_COLLECT_LAST_CHECK_EN is defined.
module vector_pair_collect_ctrl
    import vector_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_valid,
    input  logic          i_last,
    input  logic          i_flush,
    output logic [IW-1:0] o_idx,
    output logic          o_accept,
    output logic          o_complete,
    output logic          o_out_valid,
    output logic          o_busy,
    output logic          o_frame_err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic          r_out_valid;
    logic          w_accept;
    logic          w_complete;
    logic          w_abort;

    // Flush wins over an element presented in the same cycle.
    assign w_accept   = i_valid & ~i_flush;
    assign w_complete = w_accept & (r_idx == LAST_IDX);

`ifdef VECTOR_COLLECT_LAST_CHECK_EN
    logic r_frame_err;
    logic w_frame_err;

    // Early last abandons the partial vector; a missing last still lets the vector out.
    assign w_abort     = w_accept & i_last & (r_idx != LAST_IDX);
    assign w_frame_err = w_abort | (w_complete & ~i_last);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
        end
    end

    assign o_frame_err = r_frame_err;
`else
    logic w_unused_last;

    assign w_unused_last = i_last;
    assign w_abort       = 1'b0;
    assign o_frame_err   = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_idx_nxt = r_idx;
        if (i_flush || w_complete || w_abort) begin
            w_idx_nxt = '0;
        end else if (w_accept) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_idx       <= w_idx_nxt;
            r_out_valid <= w_complete;
        end
    end

    assign o_idx       = r_idx;
    assign o_accept    = w_accept;
    assign o_complete  = w_complete;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_idx != '0);

endmodule

// File: rtl/vector_pair_collect.sv
// Serial-to-vector front end: collects N (a,b) element pairs and issues them with a one-cycle pulse.
// Optional framing check on in_last is enabled by defining VECTOR_COLLECT_LAST_CHECK_EN.
module vector_pair_collect
    import vector_pkg::*;
#(
    parameter int BITS     = 16,
    parameter int N        = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [BITS-1:0]     a_in,
    input  logic [BITS-1:0]     b_in,
    input  logic                in_last,
    input  logic                flush,
    output logic                out_valid,
    output logic [BITS-1:0]     a [N],
    output logic [BITS-1:0]     b [N],
    output logic                busy,
    output logic [CNT_BITS-1:0] vec_count,
    output logic                frame_err
);

    localparam int IW = idx_w(N);

    logic [IW-1:0]       w_idx;
    logic                w_accept;
    logic                w_complete;
    logic                w_out_valid;
    logic                w_busy;
    logic                w_frame_err;

    logic [BITS-1:0]     r_shadow_a [N];
    logic [BITS-1:0]     r_shadow_b [N];
    logic [BITS-1:0]     r_a [N];
    logic [BITS-1:0]     r_b [N];
    logic [CNT_BITS-1:0] r_vec_count;

    vector_pair_collect_ctrl #(
        .N (N)
    ) u_ctrl (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (in_valid),
        .i_last      (in_last),
        .i_flush     (flush),
        .o_idx       (w_idx),
        .o_accept    (w_accept),
        .o_complete  (w_complete),
        .o_out_valid (w_out_valid),
        .o_busy      (w_busy),
        .o_frame_err (w_frame_err)
    );

    // NOTE: the arrays are small register files that must read as zero after reset, so they are reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                r_shadow_a[i] <= '0;
                r_shadow_b[i] <= '0;
            end
        end else if (w_accept) begin
            r_shadow_a[w_idx] <= a_in;
            r_shadow_b[w_idx] <= b_in;
        end
    end

    // The final element bypasses the shadow so the vector is visible one cycle after its last accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_vec_count <= '0;
        end else if (w_complete) begin
            for (int i = 0; i < N; i++) begin
                r_a[i] <= (i == N - 1) ? a_in : r_shadow_a[i];
                r_b[i] <= (i == N - 1) ? b_in : r_shadow_b[i];
            end
            r_vec_count <= r_vec_count + CNT_BITS'(1);
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign vec_count = r_vec_count;
    assign frame_err = w_frame_err;

endmodule
